spi_mstr_tx: RTL and testbench

SPI master transmitter for the protocol-trigger test path. On a single-cycle `wrt` strobe it drives one 8- or 16-bit MSB-first frame on `SS_n`/`SCLK`/`MOSI` and simultaneously captures `MISO`. It produces traffic for the team's SPI sniffer/trigger receiver and uses the same `edg`/`len8` semantics: `edg=1` means the slave samples on SCLK rise, `edg=0` on fall. `SCLK` is derived from `clk` by a fixed divider.

---
 rtl/spi_mstr_tx.sv | 109 ++++++++++
 tb/tb_spi_mstr_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mstr_tx.sv
// SPI master transmitter: one 8/16-bit MSB-first frame per wrt strobe, full-duplex MISO capture.
// SCLK is clk divided by SCLK_DIV; edg selects whether the slave samples on SCLK rise or fall.
module spi_mstr_tx #(
   parameter int SCLK_DIV = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt,
   input  logic [15:0] tx_data,
   input  logic        len8,
   input  logic        edg,
   input  logic        MISO,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   output logic [15:0] rx_data,
   output logic        busy,
   output logic        done
);

   localparam int H  = SCLK_DIV / 2;
   localparam int DW = (H > 1) ? $clog2(H) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;

   logic [1:0]    state;
   logic [DW-1:0] div_cnt;
   logic [4:0]    bit_cnt;
   logic [4:0]    n_bits;
   logic          edg_q;
   logic [15:0]   tx_sr;
   logic [15:0]   rx_sr;
   logic          miso_ff;
   logic          miso_s;
   logic          div_last;

   assign div_last = (div_cnt == DW'(H - 1));
   assign MOSI     = tx_sr[15];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         n_bits  <= '0;
         edg_q   <= 1'b0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         miso_ff <= 1'b0;
         miso_s  <= 1'b0;
         SS_n    <= 1'b1;
         SCLK    <= 1'b1;
         rx_data <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done    <= 1'b0;
         miso_ff <= MISO;
         miso_s  <= miso_ff;
         case (state)
            IDLE: begin
               SCLK <= !edg;
               if (wrt) begin
                  state   <= SETUP;
                  SS_n    <= 1'b0;
                  busy    <= 1'b1;
                  edg_q   <= edg;
                  tx_sr   <= len8 ? {tx_data[7:0], 8'h00} : tx_data;
                  n_bits  <= len8 ? 5'd8 : 5'd16;
                  bit_cnt <= '0;
                  rx_sr   <= '0;
                  div_cnt <= '0;
               end
            end
            SETUP, SHIFT: begin
               div_cnt <= div_last ? '0 : div_cnt + 1'b1;
               if (div_last) begin
                  SCLK <= ~SCLK;
                  // Leaving the idle level is always the sampling edge.
                  if (SCLK == !edg_q) begin
                     rx_sr   <= {rx_sr[14:0], miso_s};
                     bit_cnt <= bit_cnt + 5'd1;
                     state   <= SHIFT;
                  end else if (bit_cnt == n_bits) begin
                     state <= HOLD;
                  end else begin
                     tx_sr <= {tx_sr[14:0], 1'b0};
                  end
               end
            end
            HOLD: begin
               div_cnt <= div_last ? '0 : div_cnt + 1'b1;
               if (div_last) begin
                  state   <= IDLE;
                  SS_n    <= 1'b1;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  rx_data <= rx_sr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_mstr_tx.sv
// Scoreboard bench for spi_mstr_tx: slave model on a SCLK_DIV=32 instance, MOSI->MISO loopback on a SCLK_DIV=8 instance.
module tb_spi_mstr_tx;

   typedef struct {
      logic [15:0] rx;
      logic [15:0] sent;
      int          due;
      int          nbits;
      logic        edg;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic rst1_n = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance 0: SCLK_DIV=32 with slave model
   logic        wrt0 = 1'b0, len8_0 = 1'b0, edg0 = 1'b1, MISO0;
   logic [15:0] tx_data0 = '0;
   logic        SS_n0, SCLK0, MOSI0, busy0, done0;
   logic [15:0] rx_data0;

   spi_mstr_tx #(.SCLK_DIV(32)) dut0 (
      .clk(clk), .rst_n(rst_n), .wrt(wrt0), .tx_data(tx_data0), .len8(len8_0), .edg(edg0),
      .MISO(MISO0), .SS_n(SS_n0), .SCLK(SCLK0), .MOSI(MOSI0), .rx_data(rx_data0),
      .busy(busy0), .done(done0));

   // Instance 1: SCLK_DIV=8 with MOSI looped back to MISO
   logic        wrt1 = 1'b0, len8_1 = 1'b0, edg1 = 1'b1;
   logic [15:0] tx_data1 = '0;
   logic        SS_n1, SCLK1, MOSI1, busy1, done1;
   logic [15:0] rx_data1;

   spi_mstr_tx #(.SCLK_DIV(8)) dut1 (
      .clk(clk), .rst_n(rst1_n), .wrt(wrt1), .tx_data(tx_data1), .len8(len8_1), .edg(edg1),
      .MISO(MOSI1), .SS_n(SS_n1), .SCLK(SCLK1), .MOSI(MOSI1), .rx_data(rx_data1),
      .busy(busy1), .done(done1));

   exp_t q0[$];
   exp_t q1[$];

   // Slave model: loads its word on SS_n fall, shifts out on trailing edges, samples MOSI on sampling edges
   logic [15:0] slv_tx_word = '0, slv_sr = '0, slv_rx = '0;
   logic        slv_edg = 1'b1, slv_len8 = 1'b0;
   int          slv_edges = 0;
   assign MISO0 = slv_sr[15];

   always @(negedge SS_n0) begin
      slv_sr    = slv_len8 ? {slv_tx_word[7:0], 8'h00} : slv_tx_word;
      slv_rx    = '0;
      slv_edges = 0;
   end

   always @(SCLK0) begin
      if (!SS_n0) begin
         if (SCLK0 == slv_edg) begin
            slv_rx    = {slv_rx[14:0], MOSI0};
            slv_edges = slv_edges + 1;
         end else begin
            slv_sr = {slv_sr[14:0], 1'b0};
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors pop the scoreboard on every done pulse
   always @(negedge clk) begin
      if (done0) begin
         if (q0.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done0: got done=1 want none (cyc %0d)", cyc);
         end else begin
            exp_t e;
            e = q0.pop_front();
            chk("rx_data0", rx_data0, e.rx);
            chk("slave_rx", slv_rx, e.sent);
            chk("done_cycle", cyc, e.due);
            chk("sample_edges", slv_edges, e.nbits);
            chk("sclk_idle", SCLK0, !e.edg);
            chk("busy_at_done", busy0, 0);
            chk("ss_n_at_done", SS_n0, 1);
         end
      end
      if (done1) begin
         if (q1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done1: got done=1 want none (cyc %0d)", cyc);
         end else begin
            exp_t e;
            e = q1.pop_front();
            chk("loopback_rx", rx_data1, e.rx);
            chk("loopback_cycle", cyc, e.due);
         end
      end
   end

   // Issue one frame on instance 0; b2b waits for done and asserts wrt in the done cycle
   task automatic go0(input logic [15:0] d, input logic l8, input logic e, input logic [15:0] sw,
                      input bit b2b, input bit expect_done, output int start);
      exp_t x;
      int   nb;
      if (b2b) begin
         int n = 0;
         do begin
            @(posedge clk); #1;
            n++;
         end while (!done0 && n < 2000);
         chk("b2b_done_wait", done0, 1);
      end else begin
         edg0 = e;
         repeat (2) @(posedge clk);
         #1;
      end
      slv_tx_word = sw; slv_edg = e; slv_len8 = l8;
      edg0 = e; len8_0 = l8; tx_data0 = d; wrt0 = 1'b1;
      start = cyc;
      nb = l8 ? 8 : 16;
      if (expect_done) begin
         x.rx    = l8 ? {8'h00, sw[7:0]} : sw;
         x.sent  = l8 ? {8'h00, d[7:0]} : d;
         x.due   = start + 1 + (2 * nb + 1) * 16;
         x.nbits = nb;
         x.edg   = e;
         q0.push_back(x);
      end
      @(posedge clk); #1;
      wrt0 = 1'b0; tx_data0 = ~d; len8_0 = ~l8;
      @(negedge clk);
      chk("busy_cycle1", busy0, 1);
      chk("ss_n_cycle1", SS_n0, 0);
   endtask

   task automatic wait_done0();
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done0 && n < 2000);
      chk("done0_seen", done0, 1);
      @(posedge clk); #1;
   endtask

   task automatic run0();
      int st;
      // 16-bit, rise sampling
      go0(16'hA5C3, 1'b0, 1'b1, 16'h3C5A, 0, 1, st);
      wait_done0();
      // 8-bit, fall sampling: slave sees 8'h81, master gets 16'h00C6
      go0(16'hFF81, 1'b1, 1'b0, 16'h12C6, 0, 1, st);
      wait_done0();
      // wrt with different data mid-frame is ignored
      go0(16'h1234, 1'b0, 1'b1, 16'hBEEF, 0, 1, st);
      while (cyc < st + 100) begin @(posedge clk); #1; end
      wrt0 = 1'b1; tx_data0 = 16'hFFFF;
      @(posedge clk); #1;
      wrt0 = 1'b0;
      wait_done0();
      repeat (700) @(posedge clk);
      #1;
      // back-to-back frames, second wrt in the done cycle
      go0(16'h8001, 1'b0, 1'b0, 16'h7E7E, 0, 1, st);
      go0(16'h004B, 1'b1, 1'b0, 16'h00D2, 1, 1, st);
      wait_done0();
      // asynchronous reset mid-frame
      go0(16'h5555, 1'b0, 1'b1, 16'h0F0F, 0, 0, st);
      while (cyc < st + 200) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ss_n", SS_n0, 1);
      chk("rst_sclk", SCLK0, 1);
      chk("rst_mosi", MOSI0, 0);
      chk("rst_rx_data", rx_data0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      repeat (600) @(posedge clk);
      #1 rst_n = 1'b1;
      go0(16'hC00C, 1'b0, 1'b1, 16'h9669, 0, 1, st);
      wait_done0();
   endtask

   task automatic run1();
      for (int i = 0; i < 200; i++) begin
         exp_t        x;
         logic [15:0] d;
         logic        l8;
         int          n;
         d  = 16'($urandom);
         l8 = 1'($urandom_range(0, 1));
         edg1 = (i < 100);
         repeat (2) @(posedge clk);
         #1;
         wrt1 = 1'b1; tx_data1 = d; len8_1 = l8;
         x.rx    = l8 ? {8'h00, d[7:0]} : d;
         x.sent  = x.rx;
         x.nbits = l8 ? 8 : 16;
         x.due   = cyc + 1 + (2 * x.nbits + 1) * 4;
         x.edg   = edg1;
         q1.push_back(x);
         @(posedge clk); #1;
         wrt1 = 1'b0; tx_data1 = ~d; len8_1 = ~l8;
         n = 0;
         do begin
            @(posedge clk); #1;
            n++;
         end while (!done1 && n < 300);
         if (!done1) chk("done1_seen", done1, 1);
      end
   endtask

   initial begin
      #1 rst_n = 1'b0; rst1_n = 1'b0;
      #3;
      chk("init_ss_n", SS_n0, 1);
      chk("init_sclk", SCLK0, 1);
      chk("init_mosi", MOSI0, 0);
      chk("init_rx_data", rx_data0, 0);
      chk("init_busy", busy0, 0);
      chk("init_done", done0, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1; rst1_n = 1'b1;
      fork
         run0();
         run1();
      join
      repeat (5) @(posedge clk);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
